sgm_path_sequencer: RTL

// - Timing controller for the SGM aggregation datapath. Tracks row/column from de_in/h_sync_in/v_sync_in.
// - Generates path-beginning strobes for the horizontal, vertical and two diagonal path_cost_calculator instances.
// - Produces the ROI data-enable and line-buffer read/write addresses used to store previous-row path costs.
// - Sits between the video input and the path cost calculators; replaces the fixed col-compare strobe.

---
 rtl/sgm_path_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sgm_path_sequencer.sv
// Row/column timing controller that issues path-begin strobes, ROI enable and line-buffer addresses for SGM aggregation.
// Optional macro SGM_SEQ_FRAME_STATS_EN adds frame_cnt and lines_in_frame outputs.
module sgm_path_sequencer #(
   parameter int ROW_WIDTH  = 10,
   parameter int COL_WIDTH  = 11,
   parameter int IMG_WIDTH  = 800,
   parameter int ROI_START  = 400,
   parameter int ROI_END    = 799,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  de_in,
   input  logic                  h_sync_in,
   input  logic                  v_sync_in,
   output logic                  roi_de,
   output logic                  horiz_begin,
   output logic                  vert_begin,
   output logic                  diag_lr_begin,
   output logic                  diag_rl_begin,
   output logic [ADDR_WIDTH-1:0] lb_wr_addr,
   output logic [ADDR_WIDTH-1:0] lb_rd_addr,
   output logic                  line_err
`ifdef SGM_SEQ_FRAME_STATS_EN
   ,
   output logic [15:0]           frame_cnt,
   output logic [ROW_WIDTH-1:0]  lines_in_frame
`endif
);

   localparam logic [COL_WIDTH-1:0] ROI_START_C = COL_WIDTH'(ROI_START);
   localparam logic [COL_WIDTH-1:0] ROI_END_C   = COL_WIDTH'(ROI_END);
   localparam logic [COL_WIDTH-1:0] IMG_WIDTH_C = COL_WIDTH'(IMG_WIDTH);
   localparam logic [COL_WIDTH-1:0] COL_MAX     = '1;

   typedef enum logic [1:0] {
      IDLE,
      FRAME_WAIT,
      ACTIVE,
      BLANK
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [ROW_WIDTH-1:0]   row;
   logic [COL_WIDTH-1:0]   col;
   logic                   col_ovf;
   logic                   first_row;

   logic                   roi_de_n;
   logic                   horiz_n;
   logic                   vert_n;
   logic                   diag_lr_n;
   logic                   diag_rl_n;
   logic [ADDR_WIDTH-1:0]  wr_addr_n;
   logic [ADDR_WIDTH-1:0]  rd_addr_n;
   logic                   line_end_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (v_sync_in) state_next = FRAME_WAIT;
         FRAME_WAIT: if (de_in)     state_next = ACTIVE;
         ACTIVE:     if (!de_in)    state_next = BLANK;
         BLANK:      if (de_in)     state_next = ACTIVE;
         default:                   state_next = IDLE;
      endcase
      if (v_sync_in) begin
         state_next = FRAME_WAIT;
      end
   end

   // A pixel counts only outside IDLE, without a coincident frame sync, and while col is not saturated.
   // The first pixel seen in BLANK starts a new row, so it never belongs to the first row.
   always_comb begin
      logic pix;
      logic in_roi;
      logic first_eff;
      pix       = de_in && !v_sync_in && (state != IDLE) && !col_ovf;
      in_roi    = (col >= ROI_START_C) && (col <= ROI_END_C);
      first_eff = (state == BLANK) ? 1'b0 : first_row;
      roi_de_n  = pix && in_roi;
      horiz_n   = roi_de_n && (col == ROI_START_C);
      vert_n    = roi_de_n && first_eff;
      diag_lr_n = vert_n || (roi_de_n && (col == ROI_START_C));
      diag_rl_n = vert_n || (roi_de_n && (col == ROI_END_C));
      wr_addr_n = lb_wr_addr;
      rd_addr_n = lb_rd_addr;
      if (roi_de_n) begin
         wr_addr_n = ADDR_WIDTH'(col - ROI_START_C);
         rd_addr_n = (col == ROI_END_C) ? '0 : ADDR_WIDTH'(col - ROI_START_C + COL_WIDTH'(1));
      end
      line_end_bad = (state == ACTIVE) && !de_in && !v_sync_in && (col_ovf || (col != IMG_WIDTH_C));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row       <= '0;
         first_row <= 1'b0;
      end else if (v_sync_in) begin
         row       <= '0;
         first_row <= 1'b1;
      end else if ((state == BLANK) && de_in) begin
         row       <= row + ROW_WIDTH'(1);
         first_row <= 1'b0;
      end
   end

   // col holds the index of the next pixel; it sticks at its maximum and flags overflow on over-long lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col     <= '0;
         col_ovf <= 1'b0;
      end else if (v_sync_in || h_sync_in || !de_in || (state == IDLE)) begin
         col     <= '0;
         col_ovf <= 1'b0;
      end else if (col == COL_MAX) begin
         col_ovf <= 1'b1;
      end else begin
         col <= col + COL_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         roi_de        <= 1'b0;
         horiz_begin   <= 1'b0;
         vert_begin    <= 1'b0;
         diag_lr_begin <= 1'b0;
         diag_rl_begin <= 1'b0;
         lb_wr_addr    <= '0;
         lb_rd_addr    <= '0;
         line_err      <= 1'b0;
      end else begin
         roi_de        <= roi_de_n;
         horiz_begin   <= horiz_n;
         vert_begin    <= vert_n;
         diag_lr_begin <= diag_lr_n;
         diag_rl_begin <= diag_rl_n;
         lb_wr_addr    <= wr_addr_n;
         lb_rd_addr    <= rd_addr_n;
         if (line_end_bad) begin
            line_err <= 1'b1;
         end
      end
   end

`ifdef SGM_SEQ_FRAME_STATS_EN
   logic v_sync_q;

   // Stats advance once per frame-sync pulse, capturing the row count of the frame just ended.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_sync_q       <= 1'b0;
         frame_cnt      <= '0;
         lines_in_frame <= '0;
      end else begin
         v_sync_q <= v_sync_in;
         if (v_sync_in && !v_sync_q) begin
            frame_cnt      <= frame_cnt + 16'd1;
            lines_in_frame <= row + ROW_WIDTH'(1);
         end
      end
   end
`endif

endmodule
